norm_share_sched: RTL and testbench
===================================

Name: norm_share_sched

Overview:
- Schedules one shared post-add normalizer between NUM_REQ FMA lanes.
- Each lane presents a raw 3*(SIG_WIDTH+1)+6-bit product/sum word plus its pre-normalization exponent.
- The block picks requesters round-robin, computes the leading-zero shift, left-shifts, and adjusts the exponent.
- Results return through a 2-stage valid/ready pipeline tagged with the requester id; the block sits between the lane adders and the rounding stage.

Parameters:
SIG_WIDTH, 23, significand width excluding hidden bit.
EXP_WIDTH, 8, exponent width.
NUM_REQ, 2, number of requesting lanes, legal 2..4.
EXP_OFFSET, 31, shift amount that leaves the exponent unchanged.
(Derived: IN_W = 3*(SIG_WIDTH+1)+6 = 78 at defaults.)

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-lane request valid.
req_ready  out  NUM_REQ  per-lane accept; at most one bit high per cycle.
req_data  in  NUM_REQ*IN_W  lane i word at [i*IN_W +: IN_W].
req_exp  in  NUM_REQ*EXP_WIDTH  lane i exponent at [i*EXP_WIDTH +: EXP_WIDTH].
out_valid  out  1  result valid.
out_ready  in  1  downstream accept.
out_sig  out  SIG_WIDTH+1  normalized significand, top SIG_WIDTH+1 bits after shift.
out_exp  out  EXP_WIDTH  adjusted exponent.
out_id  out  2  index of the originating lane.
out_zero  out  1  input word was all zero.
busy  out  1  stage A or stage B holds a valid entry.

Behaviour:
- Reset (async assert, sync release): a_vld=0, b_vld=0, rr_ptr=0. All outputs are 0: out_valid, out_sig, out_exp, out_id, out_zero, busy, req_ready.
- Reset asserted mid-operation discards both stages; no partial result is emitted.

Arbitration:
- Round-robin search begins at rr_ptr and wraps modulo NUM_REQ. The first lane with req_valid set wins.
- req_ready[win] = load_a; all other bits are 0. req_ready is 0 for every lane when no lane is valid.
- On each accept (req_valid & req_ready), rr_ptr <= (win+1) mod NUM_REQ. Otherwise rr_ptr holds.

Pipeline:
- adv_b = !b_vld | out_ready.
- load_a = !a_vld | adv_b.
- Stage A, on accept: captures data, exp and id, and sets a_vld. If load_a is high with no accept, a_vld is cleared.
- Stage A, combinational: num = leading-zero count of the captured data, range 0..IN_W.
- Stage B, on adv_b: captures stage A results, and b_vld <= a_vld.
  - out_sig = (data << num)[IN_W-1 -: SIG_WIDTH+1].
  - num > EXP_OFFSET: out_exp = exp - (num - EXP_OFFSET).
  - num <= EXP_OFFSET: out_exp = exp + (EXP_OFFSET - num).
  - Arithmetic is modulo 2^EXP_WIDTH.
- Zero input (num == IN_W): out_sig=0, out_exp=0, out_zero=1.
- Latency: accept in cycle t gives out_valid in cycle t+2. Throughput is 1 result per cycle when out_ready is held high.
- While out_valid=1 and out_ready=0, all out_* values stay stable.
- When both stages are full and stalled, req_ready is all 0. Simultaneous drain and accept in the same cycle is legal.
- out_valid = b_vld. busy = a_vld | b_vld.

Optional Feature:
Macro NORM_EXP_SAT_EN.
- Defined: adds output ports out_uflow and out_oflow (1 bit each, reset 0). Exponent arithmetic is done at EXP_WIDTH+2 bits, signed.
  - Result below 0: out_exp=0, out_uflow=1.
  - Result above 2^EXP_WIDTH-1: out_exp all ones, out_oflow=1.
  - Zero input sets neither flag.
- Undefined: the ports are absent and exponent arithmetic wraps modulo 2^EXP_WIDTH.

Test Plan:
1. Lane0 only, req_data=1<<77, req_exp=100, out_ready=1 → two cycles after accept: out_sig=24'h800000, out_exp=131, out_id=0, out_zero=0.
2. Lane1 only, req_data=1<<46, req_exp=100 → num=31; out_sig=24'h800000, out_exp=100, out_id=1.
3. Both lanes valid every cycle, out_ready=1 → accepts alternate lane0, lane1, lane0, ...; one result per cycle with out_id sequence 0,1,0,1.
4. Stream lane0, hold out_ready=0 for 3 cycles → out_valid stays high with stable data, and req_ready=0 once both stages are full. Release out_ready → no result lost or duplicated.
5. req_data=0, req_exp=50 → out_zero=1, out_sig=0, out_exp=0. Pulse rst_n low while both stages hold data → out_valid=0 and busy=0 immediately; no result after release.
6. req_data=1, req_exp=10 (num=77):
   - Without NORM_EXP_SAT_EN: out_exp=220.
   - With NORM_EXP_SAT_EN: out_exp=0 and out_uflow=1.
   - With NORM_EXP_SAT_EN, req_data=1<<77, req_exp=250: out_exp=255 and out_oflow=1.

Source files
------------

// File: rtl/norm_share_sched.sv
// -----------------------------------------------------------------------------
// norm_share_sched
//
// Shares one post-add normalizer between NUM_REQ FMA lanes. A round-robin
// arbiter picks one requesting lane per cycle. Stage A holds the accepted
// word and computes its leading-zero count. Stage B registers the shifted
// significand, the adjusted exponent and the lane id for the rounding stage.
// Results leave through a valid/ready handshake with a latency of two cycles.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-lane request valid                  [NUM_REQ]
//   req_ready  : per-lane accept, at most one bit high    [NUM_REQ]
//   req_data   : lane i raw word at [i*IN_W +: IN_W]      [NUM_REQ*IN_W]
//   req_exp    : lane i exponent at [i*EXP_WIDTH +: EXP_WIDTH]
//   out_valid  : result valid
//   out_ready  : downstream accept
//   out_sig    : normalized significand (top SIG_WIDTH+1 bits after shift)
//   out_exp    : adjusted exponent
//   out_id     : originating lane
//   out_zero   : input word was all zero
//   busy       : stage A or stage B holds an entry
//   out_uflow  : exponent clamped to 0          (NORM_EXP_SAT_EN only)
//   out_oflow  : exponent clamped to all ones   (NORM_EXP_SAT_EN only)
//
// Build option
//   NORM_EXP_SAT_EN : when defined, the exponent is computed signed at
//                     EXP_WIDTH+2 bits and saturated, and out_uflow/out_oflow
//                     are added. When undefined, the exponent wraps modulo
//                     2^EXP_WIDTH.
// -----------------------------------------------------------------------------
module norm_share_sched #(
    parameter int SIG_WIDTH  = 23,
    parameter int EXP_WIDTH  = 8,
    parameter int NUM_REQ    = 2,
    parameter int EXP_OFFSET = 31,
    localparam int IN_W      = 3 * (SIG_WIDTH + 1) + 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*IN_W-1:0]        req_data,
    input  logic [NUM_REQ*EXP_WIDTH-1:0]   req_exp,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SIG_WIDTH:0]             out_sig,
    output logic [EXP_WIDTH-1:0]           out_exp,
    output logic [1:0]                     out_id,
    output logic                           out_zero,
`ifdef NORM_EXP_SAT_EN
    output logic                           out_uflow,
    output logic                           out_oflow,
`endif
    output logic                           busy
);

    localparam int SIG_W = SIG_WIDTH + 1;
    localparam int NUM_W = $clog2(IN_W + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           rr_ptr_q, rr_ptr_d;

    logic                 a_vld_q, a_vld_d;
    logic [IN_W-1:0]      a_data_q, a_data_d;
    logic [EXP_WIDTH-1:0] a_exp_q, a_exp_d;
    logic [1:0]           a_id_q, a_id_d;

    logic                 b_vld_q, b_vld_d;
    logic [SIG_W-1:0]     b_sig_q, b_sig_d;
    logic [EXP_WIDTH-1:0] b_exp_q, b_exp_d;
    logic [1:0]           b_id_q, b_id_d;
    logic                 b_zero_q, b_zero_d;
`ifdef NORM_EXP_SAT_EN
    logic                 b_uflow_q, b_uflow_d;
    logic                 b_oflow_q, b_oflow_d;
`endif

    // ------------------------------------------------------------------
    // Pipeline flow control
    // ------------------------------------------------------------------
    logic adv_b;
    logic load_a;

    assign adv_b  = !b_vld_q || out_ready;
    assign load_a = !a_vld_q || adv_b;

    // ------------------------------------------------------------------
    // Round-robin arbitration: position k of the search is lane
    // (rr_ptr + k) mod NUM_REQ; the first valid lane in that order wins.
    // ------------------------------------------------------------------
    logic                 found;
    logic [1:0]           win;
    logic [IN_W-1:0]      sel_data;
    logic [EXP_WIDTH-1:0] sel_exp;
    logic                 grant;
    int                   cand;

    always_comb begin
        found    = 1'b0;
        win      = 2'd0;
        sel_data = '0;
        sel_exp  = '0;
        cand     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] && (cand == i)) begin
                    found    = 1'b1;
                    win      = 2'(i);
                    sel_data = req_data[i*IN_W +: IN_W];
                    sel_exp  = req_exp[i*EXP_WIDTH +: EXP_WIDTH];
                end
            end
        end
    end

    assign grant = found && load_a;

    // req_ready is forced low while reset is asserted so no lane sees an
    // accept that the held-in-reset pipeline would never capture.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && rst_n && (win == 2'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            if (win == 2'(NUM_REQ - 1)) begin
                rr_ptr_d = 2'd0;
            end else begin
                rr_ptr_d = win + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage A: capture
    // ------------------------------------------------------------------
    always_comb begin
        a_vld_d  = a_vld_q;
        a_data_d = a_data_q;
        a_exp_d  = a_exp_q;
        a_id_d   = a_id_q;
        if (load_a) begin
            a_vld_d = grant;
        end
        if (grant) begin
            a_data_d = sel_data;
            a_exp_d  = sel_exp;
            a_id_d   = win;
        end
    end

    // ------------------------------------------------------------------
    // Stage A: leading-zero count, shift, exponent adjust
    // ------------------------------------------------------------------
    logic [NUM_W-1:0]     lz;
    logic                 a_zero;
    logic [SIG_W-1:0]     a_sig;
    logic [EXP_WIDTH-1:0] a_exp_adj;
`ifdef NORM_EXP_SAT_EN
    localparam int AW = EXP_WIDTH + 2;
    logic signed [AW-1:0] exp_wide;
    logic                 a_uflow;
    logic                 a_oflow;
`endif

    // Ascending scan: the highest set bit is the last one written.
    always_comb begin
        lz = NUM_W'(IN_W);
        for (int i = 0; i < IN_W; i++) begin
            if (a_data_q[i]) begin
                lz = NUM_W'(IN_W - 1 - i);
            end
        end
    end

    assign a_zero = (lz == NUM_W'(IN_W));

    always_comb begin
        a_sig     = SIG_W'((a_data_q << lz) >> (IN_W - SIG_W));
`ifdef NORM_EXP_SAT_EN
        a_uflow   = 1'b0;
        a_oflow   = 1'b0;
        exp_wide  = $signed({2'b00, a_exp_q}) + $signed(AW'(EXP_OFFSET))
                    - $signed(AW'(lz));
        if (exp_wide < $signed(AW'(0))) begin
            a_exp_adj = '0;
            a_uflow   = 1'b1;
        end else if (exp_wide > $signed(AW'((1 << EXP_WIDTH) - 1))) begin
            a_exp_adj = '1;
            a_oflow   = 1'b1;
        end else begin
            a_exp_adj = exp_wide[EXP_WIDTH-1:0];
        end
`else
        // exp + (EXP_OFFSET - num) covers both shift directions when the
        // result is allowed to wrap.
        a_exp_adj = a_exp_q + EXP_WIDTH'(EXP_OFFSET) - EXP_WIDTH'(lz);
`endif
        if (a_zero) begin
            a_sig     = '0;
            a_exp_adj = '0;
`ifdef NORM_EXP_SAT_EN
            a_uflow   = 1'b0;
            a_oflow   = 1'b0;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage B: output register, held while stalled
    // ------------------------------------------------------------------
    always_comb begin
        b_vld_d   = b_vld_q;
        b_sig_d   = b_sig_q;
        b_exp_d   = b_exp_q;
        b_id_d    = b_id_q;
        b_zero_d  = b_zero_q;
`ifdef NORM_EXP_SAT_EN
        b_uflow_d = b_uflow_q;
        b_oflow_d = b_oflow_q;
`endif
        if (adv_b) begin
            b_vld_d = a_vld_q;
            if (a_vld_q) begin
                b_sig_d   = a_sig;
                b_exp_d   = a_exp_adj;
                b_id_d    = a_id_q;
                b_zero_d  = a_zero;
`ifdef NORM_EXP_SAT_EN
                b_uflow_d = a_uflow;
                b_oflow_d = a_oflow;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            a_vld_q   <= 1'b0;
            a_data_q  <= '0;
            a_exp_q   <= '0;
            a_id_q    <= '0;
            b_vld_q   <= 1'b0;
            b_sig_q   <= '0;
            b_exp_q   <= '0;
            b_id_q    <= '0;
            b_zero_q  <= 1'b0;
`ifdef NORM_EXP_SAT_EN
            b_uflow_q <= 1'b0;
            b_oflow_q <= 1'b0;
`endif
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            a_vld_q   <= a_vld_d;
            a_data_q  <= a_data_d;
            a_exp_q   <= a_exp_d;
            a_id_q    <= a_id_d;
            b_vld_q   <= b_vld_d;
            b_sig_q   <= b_sig_d;
            b_exp_q   <= b_exp_d;
            b_id_q    <= b_id_d;
            b_zero_q  <= b_zero_d;
`ifdef NORM_EXP_SAT_EN
            b_uflow_q <= b_uflow_d;
            b_oflow_q <= b_oflow_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = b_vld_q;
    assign out_sig   = b_sig_q;
    assign out_exp   = b_exp_q;
    assign out_id    = b_id_q;
    assign out_zero  = b_zero_q;
    assign busy      = a_vld_q || b_vld_q;
`ifdef NORM_EXP_SAT_EN
    assign out_uflow = b_uflow_q;
    assign out_oflow = b_oflow_q;
`endif

endmodule

// File: tb/tb_norm_share_sched.sv
module tb_norm_share_sched;

    localparam int SIG_WIDTH = 23;
    localparam int EXP_WIDTH = 8;
    localparam int NUM_REQ   = 2;
    localparam int IN_W      = 3 * (SIG_WIDTH + 1) + 6;

    logic                         clk;
    logic                         rst_n;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*IN_W-1:0]      req_data;
    logic [NUM_REQ*EXP_WIDTH-1:0] req_exp;
    logic                         out_valid;
    logic                         out_ready;
    logic [SIG_WIDTH:0]           out_sig;
    logic [EXP_WIDTH-1:0]         out_exp;
    logic [1:0]                   out_id;
    logic                         out_zero;
    logic                         busy;
`ifdef NORM_EXP_SAT_EN
    logic                         out_uflow;
    logic                         out_oflow;
`endif

    norm_share_sched #(
        .SIG_WIDTH (SIG_WIDTH),
        .EXP_WIDTH (EXP_WIDTH),
        .NUM_REQ   (NUM_REQ),
        .EXP_OFFSET(31)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_exp  (req_exp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sig  (out_sig),
        .out_exp  (out_exp),
        .out_id   (out_id),
        .out_zero (out_zero),
`ifdef NORM_EXP_SAT_EN
        .out_uflow(out_uflow),
        .out_oflow(out_oflow),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SIG_WIDTH:0]   sig;
        logic [EXP_WIDTH-1:0] e;
        logic [1:0]           id;
        logic                 z;
        logic                 uf;
        logic                 of;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done;
    bit   ok;

    function automatic logic [IN_W-1:0] bit1(input int n);
        logic [IN_W-1:0] v;
        v = 1;
        return v << n;
    endfunction

    function automatic void push(input logic [SIG_WIDTH:0] s, input logic [EXP_WIDTH-1:0] e,
                                 input logic [1:0] id, input logic z, input logic uf, input logic of);
        exp_t x;
        x.sig = s; x.e = e; x.id = id; x.z = z; x.uf = uf; x.of = of;
        sb.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Drive one request on a lane until accepted; returns at posedge+1.
    task automatic send(input int lane, input logic [IN_W-1:0] d, input logic [EXP_WIDTH-1:0] e);
        bit acc;
        acc = 1'b0;
        req_data[lane*IN_W +: IN_W]        = d;
        req_exp[lane*EXP_WIDTH +: EXP_WIDTH] = e;
        req_valid[lane]                    = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            if (req_ready[lane]) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid[lane] = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout lane=%0d got=no_accept want=accept", lane);
        end
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 100 && !idle; n++) begin
            @(negedge clk);
            if (!busy && stim_done) idle = 1'b1;
        end
        checks++;
        if (!idle) begin
            failures++;
            $display("FAIL drain_timeout got=busy want=idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL out_valid_timeout got=0 want=1");
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!$onehot0(req_ready)) begin
                failures++;
                $display("FAIL ready_onehot got=%b want=onehot0", req_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out got id=%0d sig=%h exp=%0d want=no_output",
                             out_id, out_sig, out_exp);
                end else begin
                    mon_e = sb.pop_front();
                    if (out_sig !== mon_e.sig || out_exp !== mon_e.e || out_id !== mon_e.id ||
                        out_zero !== mon_e.z
`ifdef NORM_EXP_SAT_EN
                        || out_uflow !== mon_e.uf || out_oflow !== mon_e.of
`endif
                        ) begin
                        failures++;
                        $display("FAIL out_result got sig=%h exp=%0d id=%0d zero=%b want sig=%h exp=%0d id=%0d zero=%b uf=%b of=%b",
                                 out_sig, out_exp, out_id, out_zero,
                                 mon_e.sig, mon_e.e, mon_e.id, mon_e.z, mon_e.uf, mon_e.of);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_done = 1'b1;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_data  = '0;
        req_exp   = '0;
        out_ready = 1'b1;

        // Reset state, with requests pending
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_sig",   out_sig,   0);
        chk("rst_out_exp",   out_exp,   0);
        chk("rst_out_id",    out_id,    0);
        chk("rst_out_zero",  out_zero,  0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: lane0, num=0 -> exp 100+31
        push(24'h800000, 8'd131, 2'd0, 1'b0, 1'b0, 1'b0);
        send(0, bit1(77), 8'd100);
        @(negedge clk);
        chk("lat_t1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_t2_valid", out_valid, 1);
        drain();

        // 2: lane1, num=31 -> exp unchanged
        push(24'h800000, 8'd100, 2'd1, 1'b0, 1'b0, 1'b0);
        send(1, bit1(46), 8'd100);
        drain();

        // 3: both lanes valid, round robin from lane0
        push(24'h800000, 8'd131, 2'd0, 1'b0, 1'b0, 1'b0);
        push(24'h800000, 8'd100, 2'd1, 1'b0, 1'b0, 1'b0);
        push(24'h800000, 8'd131, 2'd0, 1'b0, 1'b0, 1'b0);
        push(24'h800000, 8'd100, 2'd1, 1'b0, 1'b0, 1'b0);
        req_data  = {bit1(46), bit1(77)};
        req_exp   = {8'd100, 8'd100};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i >= 2) chk("rr_throughput_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        drain();

        // 4: backpressure on a lane0 stream
        push(24'h800000, 8'd131, 2'd0, 1'b0, 1'b0, 1'b0);
        push(24'hC00000, 8'd125, 2'd0, 1'b0, 1'b0, 1'b0);
        push(24'hABCDEF, 8'd121, 2'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        stim_done = 1'b0;
        fork
            begin
                send(0, bit1(77), 8'd100);
                send(0, bit1(71) | bit1(70), 8'd100);
                send(0, {54'd0, 24'hABCDEF} << 44, 8'd100);
                stim_done = 1'b1;
            end
        join_none
        wait_out_valid();
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            chk("stall_valid",     out_valid, 1);
            chk("stall_sig",       out_sig,   24'h800000);
            chk("stall_exp",       out_exp,   131);
            chk("stall_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("stream_sb_empty", sb.size(), 0);

        // 5a: zero word
        push(24'h000000, 8'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        send(0, '0, 8'd50);
        drain();

        // 5b: reset while both stages are full; nothing may emerge
        out_ready = 1'b0;
        stim_done = 1'b0;
        fork
            begin
                send(0, bit1(77), 8'd100);
                send(1, bit1(46), 8'd100);
                stim_done = 1'b1;
            end
        join_none
        wait_out_valid();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy",      busy,      0);
        chk("midrst_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("postrst_out_valid", out_valid, 0);
        chk("postrst_busy",      busy,      0);
        chk("postrst_sb_empty",  sb.size(), 0);
        @(posedge clk);
        #1;

        // 6: num=77 exponent adjust
`ifdef NORM_EXP_SAT_EN
        push(24'h800000, 8'd0, 2'd1, 1'b0, 1'b1, 1'b0);
        send(1, bit1(0), 8'd10);
        drain();
        push(24'h800000, 8'd255, 2'd0, 1'b0, 1'b0, 1'b1);
        send(0, bit1(77), 8'd250);
        drain();
`else
        push(24'h800000, 8'd220, 2'd1, 1'b0, 1'b0, 1'b0);
        send(1, bit1(0), 8'd10);
        drain();
`endif

        chk("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
